// File: rtl/lcd_value_formatter_if.sv
// Request/result bundle between a value producer and lcd_value_formatter.
// The master drives the request; the slave (formatter) returns display codes.
interface lcd_value_formatter_if;
  logic        start;
  logic [27:0] value;
  logic        dp_en;
  logic [2:0]  dp_pos;
  logic [4:0]  char7;
  logic [4:0]  char6;
  logic [4:0]  char5;
  logic [4:0]  char4;
  logic [4:0]  char3;
  logic [4:0]  char2;
  logic [4:0]  char1;
  logic [4:0]  char0;
  logic [7:0]  point;
  logic        busy;
  logic        done;

  modport master (
    output start, value, dp_en, dp_pos,
    input  char7, char6, char5, char4, char3, char2, char1, char0,
    input  point, busy, done
  );

  modport slave (
    input  start, value, dp_en, dp_pos,
    output char7, char6, char5, char4, char3, char2, char1, char0,
    output point, busy, done
  );
endinterface

// File: rtl/lcd_value_formatter.sv
// Signed 28-bit value to eight LCD character codes: serial double-dabble,
// then blanking, sign placement and overflow marking into held output registers.
module lcd_value_formatter #(
  parameter bit         LZB        = 1'b1,
  parameter logic [4:0] CHAR_BLANK = 5'd16,
  parameter logic [4:0] CHAR_MINUS = 5'd17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lcd_value_formatter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [27:0]     mag_r;
  logic [31:0]     bcd_r;
  logic [4:0]      cnt_r;
  logic            neg_r;
  logic            dp_en_r;
  logic [2:0]      dp_pos_r;
  logic            bcd_ovf_r;
  logic            big_pos_r;
  logic            big_neg_r;
  logic [7:0][4:0] char_r;
  logic [7:0]      point_r;
  logic            busy_r;
  logic            done_r;

  logic [27:0]     abs_s;
  logic [31:0]     adj_s;
  logic [7:0]      blank_s;
  logic            upper_zero_s;
  logic            has_blank_s;
  logic [2:0]      minus_pos_s;
  logic            ovf_s;
  logic [7:0][4:0] fmt_char_s;
  logic [7:0]      fmt_point_s;

  // Add 3 to every nibble >= 5 ahead of the doubling shift.
  function automatic logic [31:0] dabble(input logic [31:0] bcd);
    logic [31:0] adj;
    for (int i = 0; i < 8; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? (bcd[4*i +: 4] + 4'd3) : bcd[4*i +: 4];
    end
    return adj;
  endfunction

  // Next-state logic for the conversion sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (bus.start) state_s = ST_SHIFT; else state_s = ST_IDLE;
      ST_SHIFT:  if (cnt_r == 5'd27) state_s = ST_FORMAT; else state_s = ST_SHIFT;
      ST_FORMAT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Magnitude of the request and the per-cycle BCD correction.
  always_comb begin
    abs_s = bus.value[27] ? (~bus.value + 28'd1) : bus.value;
    adj_s = dabble(bcd_r);
  end

  // Blanking runs top-down, so the blanked set is always a contiguous upper run.
  always_comb begin
    upper_zero_s = 1'b1;
    blank_s      = 8'd0;
    minus_pos_s  = 3'd7;
    for (int k = 7; k >= 0; k--) begin
      upper_zero_s = upper_zero_s && (bcd_r[4*k +: 4] == 4'd0);
      if ((k > 0) && upper_zero_s && !(dp_en_r && (3'(k) <= dp_pos_r))) begin
        blank_s[k] = 1'b1;
      end else begin
        blank_s[k] = 1'b0;
      end
    end
    for (int k = 7; k >= 1; k--) begin
      if (blank_s[k]) minus_pos_s = 3'(k); else minus_pos_s = minus_pos_s;
    end
    has_blank_s = |blank_s;
  end

  // Assemble the character codes and point vector captured on the FORMAT edge.
  always_comb begin
    if (neg_r) begin
      ovf_s = big_neg_r || (!LZB && (bcd_r[31:28] != 4'd0));
    end else begin
      ovf_s = bcd_ovf_r || big_pos_r;
    end
    for (int k = 0; k < 8; k++) begin
      fmt_char_s[k] = (LZB && blank_s[k]) ? CHAR_BLANK : {1'b0, bcd_r[4*k +: 4]};
    end
    fmt_point_s = dp_en_r ? (8'd1 << dp_pos_r) : 8'd0;
    if (neg_r && LZB && has_blank_s) begin
      fmt_char_s[minus_pos_s] = CHAR_MINUS;
    end else if (neg_r && !LZB) begin
      fmt_char_s[7] = CHAR_MINUS;
    end else begin
      fmt_char_s = fmt_char_s;
    end
    if (ovf_s) begin
      fmt_char_s  = {8{CHAR_MINUS}};
      fmt_point_s = 8'd0;
    end else begin
      fmt_point_s = fmt_point_s;
    end
  end

  // Sequencer state and conversion datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      mag_r     <= 28'd0;
      bcd_r     <= 32'd0;
      cnt_r     <= 5'd0;
      neg_r     <= 1'b0;
      dp_en_r   <= 1'b0;
      dp_pos_r  <= 3'd0;
      bcd_ovf_r <= 1'b0;
      big_pos_r <= 1'b0;
      big_neg_r <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            mag_r     <= abs_s;
            neg_r     <= bus.value[27];
            dp_en_r   <= bus.dp_en;
            dp_pos_r  <= bus.dp_pos;
            bcd_r     <= 32'd0;
            cnt_r     <= 5'd0;
            bcd_ovf_r <= 1'b0;
            big_pos_r <= (abs_s > 28'd99999999);
            big_neg_r <= (abs_s > 28'd9999999);
          end
        end
        ST_SHIFT: begin
          bcd_r     <= {adj_s[30:0], mag_r[27]};
          mag_r     <= {mag_r[26:0], 1'b0};
          bcd_ovf_r <= bcd_ovf_r | adj_s[31];
          cnt_r     <= cnt_r + 5'd1;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Displayed result registers: they change only on the FORMAT edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_r  <= {8{CHAR_BLANK}};
      point_r <= 8'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= (state_r == ST_FORMAT);
      if (state_r == ST_FORMAT) begin
        char_r  <= fmt_char_s;
        point_r <= fmt_point_s;
        busy_r  <= 1'b0;
      end else if ((state_r == ST_IDLE) && bus.start) begin
        busy_r <= 1'b1;
      end
    end
  end

  assign bus.char7 = char_r[7];
  assign bus.char6 = char_r[6];
  assign bus.char5 = char_r[5];
  assign bus.char4 = char_r[4];
  assign bus.char3 = char_r[3];
  assign bus.char2 = char_r[2];
  assign bus.char1 = char_r[1];
  assign bus.char0 = char_r[0];
  assign bus.point = point_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule
